am2940_seq: RTL and testbench

Transfer sequencer sitting directly upstream of the `am2940` DMA address generator. It drives that block's `instr`, `data`, `aci`, `wci` and `oeaddr` inputs. On a host start it programs the control register, address register/counter and word-count register/counter. It then runs a req/ack beat handshake with a peripheral, advancing the address and word counters once per beat until the generator's `done` output ends the transfer.

---
 rtl/am2940_pkg.sv | 16 +
 rtl/am2940_seq_wdog.sv | 18 +
 rtl/am2940_seq.sv | 98 +++++++++
 tb/tb_am2940_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/am2940_pkg.sv
// am2940_pkg: am2940 instruction codes and sequencer state encoding
package am2940_pkg;
    localparam logic [2:0] I_WR_CR   = 3'd0;
    localparam logic [2:0] I_LD_ADDR = 3'd5;
    localparam logic [2:0] I_LD_WC   = 3'd6;
    localparam logic [2:0] I_ENABLE  = 3'd7;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CR,
        S_LD_ADDR,
        S_LD_WC,
        S_WAIT_REQ,
        S_XFER,
        S_FINISH
    } state_t;
endpackage

// File: rtl/am2940_seq_wdog.sv
// am2940_seq_wdog: counts consecutive idle WAIT_REQ cycles and flags the timeout cycle
module am2940_seq_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_idle,
    output logic o_timeout
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] r_cnt;
    assign o_timeout = i_idle && (r_cnt == W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_cnt <= '0;
        else if (i_idle) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/am2940_seq.sv
// am2940_seq: am2940 setup and req/ack beat sequencer; idle watchdog under AM2940_SEQ_TIMEOUT_EN
module am2940_seq
    import am2940_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_count,
    input  logic [2:0] cfg_mode,
    input  logic       dev_req,
    output logic       dev_ack,
    input  logic       am_done,
    output logic [2:0] am_instr,
    output logic [7:0] am_data,
    output logic       am_aci,
    output logic       am_wci,
    output logic       am_oeaddr,
    output logic       busy,
    output logic       irq,
    output logic       err,
    output logic [7:0] beats
);
    state_t r_state, w_next;
    logic [7:0] r_addr, r_count;
    logic w_start, w_timeout, w_abort, w_xfer;
    assign w_start = (r_state == S_IDLE) && start;
    assign w_abort = (r_state != S_IDLE) && abort;
    assign w_xfer  = (w_next == S_XFER);
`ifdef AM2940_SEQ_TIMEOUT_EN
    am2940_seq_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_start || (r_state == S_XFER)),
        .i_idle   ((r_state == S_WAIT_REQ) && !dev_req && !am_done),
        .o_timeout(w_timeout)
    );
`else
    logic w_unused;
    assign w_unused  = |TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     w_next = start ? S_WR_CR : S_IDLE;
            S_WR_CR:    w_next = S_LD_ADDR;
            S_LD_ADDR:  w_next = S_LD_WC;
            S_LD_WC:    w_next = S_WAIT_REQ;
            S_WAIT_REQ: w_next = am_done ? S_FINISH : dev_req ? S_XFER : w_timeout ? S_FINISH : S_WAIT_REQ;
            S_XFER:     w_next = S_WAIT_REQ;
            default:    w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end
    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_count   <= '0;
            am_instr  <= I_ENABLE;
            am_data   <= '0;
            am_aci    <= 1'b1;
            am_wci    <= 1'b1;
            am_oeaddr <= 1'b0;
            dev_ack   <= 1'b0;
            busy      <= 1'b0;
            irq       <= 1'b0;
            err       <= 1'b0;
            beats     <= '0;
        end else begin
            r_state   <= w_next;
            am_instr  <= (w_next == S_WR_CR) ? I_WR_CR : (w_next == S_LD_ADDR) ? I_LD_ADDR :
                         (w_next == S_LD_WC) ? I_LD_WC : I_ENABLE;
            am_data   <= (w_next == S_WR_CR) ? {5'b0, cfg_mode} : (w_next == S_LD_ADDR) ? r_addr :
                         (w_next == S_LD_WC) ? r_count : 8'h00;
            am_aci    <= !w_xfer;
            am_wci    <= !w_xfer;
            am_oeaddr <= w_xfer;
            dev_ack   <= w_xfer;
            busy      <= (w_next != S_IDLE) && (w_next != S_FINISH);
            irq       <= (w_next == S_FINISH) && !w_abort;
            if (w_start) begin
                r_addr  <= cfg_addr;
                r_count <= cfg_count;
                beats   <= '0;
                err     <= 1'b0;
            end else begin
                if (r_state == S_XFER) beats <= beats + 8'd1;
                if (w_abort || w_timeout) err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_am2940_seq.sv
// tb_am2940_seq: directed bench with an am2940 counter model and a rule-level sequencer model
module tb_am2940_seq;
    localparam int TO = 8;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, dev_req = 0, force_done = 0;
    logic [7:0] cfg_addr = 0, cfg_count = 0;
    logic [2:0] cfg_mode = 0;
    logic dev_ack, am_done, am_aci, am_wci, am_oeaddr, busy, irq, err;
    logic [2:0] am_instr;
    logic [7:0] am_data, beats;
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    am2940_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_mode(cfg_mode),
        .dev_req(dev_req), .dev_ack(dev_ack), .am_done(am_done),
        .am_instr(am_instr), .am_data(am_data), .am_aci(am_aci), .am_wci(am_wci),
        .am_oeaddr(am_oeaddr), .busy(busy), .irq(irq), .err(err), .beats(beats)
    );

    // downstream address generator: loads on instructions, steps on active-low carries
    logic [7:0] a_addr = 0, a_wc = 0;
    logic [2:0] a_cr = 0;
    assign am_done = force_done || (a_wc == 8'd0);
    always @(posedge clk) begin
        if (am_instr == 3'd0) a_cr <= am_data[2:0];
        else if (am_instr == 3'd5) a_addr <= am_data;
        else if (am_instr == 3'd6) a_wc <= am_data;
        else if (am_instr == 3'd7) begin
            if (!am_aci) a_addr <= a_cr[2] ? a_addr - 8'd1 : a_addr + 8'd1;
            if (!am_wci) a_wc <= a_wc - 8'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // sequencer model: setup writes come from a queue, then wait/beat/finish phases
    typedef struct packed { logic [2:0] i; logic [7:0] d; } slot_t;
    localparam int C_IDLE = 0, C_SETUP = 1, C_WAIT = 2, C_XFER = 3, C_FIN = 4;
    slot_t q[$];
    slot_t cur;
    int cat = C_IDLE, wd = 0;
    logic [7:0] m_beats = 0;
    bit m_err = 0, m_valid = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (!rst_n) begin
            cat = C_IDLE; q.delete(); m_beats = 0; m_err = 0; wd = 0;
        end else if (cat == C_IDLE) begin
            if (start) begin
                m_beats = 0; m_err = 0; wd = 0;
                q.push_back(slot_t'{3'd0, {5'd0, cfg_mode}});
                q.push_back(slot_t'{3'd5, cfg_addr});
                q.push_back(slot_t'{3'd6, cfg_count});
                cur = q.pop_front();
                cat = C_SETUP;
            end
        end else if (abort) begin
            if (cat == C_XFER) m_beats = m_beats + 8'd1;
            m_err = 1; cat = C_IDLE;
        end else begin
            case (cat)
                C_SETUP: if (q.size() > 0) cur = q.pop_front(); else cat = C_WAIT;
                C_WAIT: begin
                    if (am_done) cat = C_FIN;
                    else if (dev_req) cat = C_XFER;
                    else begin
                        wd++;
`ifdef AM2940_SEQ_TIMEOUT_EN
                        if (wd == TO) begin cat = C_FIN; m_err = 1; end
`endif
                    end
                end
                C_XFER: begin m_beats = m_beats + 8'd1; wd = 0; cat = C_WAIT; end
                default: cat = C_IDLE;
            endcase
        end
    end

    function automatic logic [25:0] expv();
        bit s, x;
        s = (cat == C_SETUP);
        x = (cat == C_XFER);
        return {s ? cur.i : 3'd7, s ? cur.d : 8'd0, !x, !x, x, x,
                (cat != C_IDLE) && (cat != C_FIN), cat == C_FIN, m_err, m_beats};
    endfunction

    always @(negedge clk)
        if (m_valid)
            chk("cycle", {6'd0, am_instr, am_data, am_aci, am_wci, am_oeaddr, dev_ack, busy, irq, err, beats},
                {6'd0, expv()});

    localparam logic [25:0] RST_V = {3'd7, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    task automatic go(input logic [7:0] a, input logic [7:0] c, input logic [2:0] m);
        cfg_addr = a; cfg_count = c; cfg_mode = m; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        logic [11:0] ak, iq, bz;
        logic [2:0] ins[1:3];
        logic [7:0] d2;
        int na, ni;
        repeat (3) @(negedge clk);
        chk("reset_vals", {am_instr, am_data, am_aci, am_wci, am_oeaddr, dev_ack, busy, irq, err, beats}, RST_V);
        rst_n = 1;
        @(negedge clk);

        // basic transfer, dev_req held high
        dev_req = 1;
        go(8'h10, 8'd3, 3'd0);
        ak = 0; iq = 0; bz = 0; d2 = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 3) ins[k] = am_instr;
            if (k == 2) d2 = am_data;
            ak[k-1] = dev_ack; iq[k-1] = irq; bz[k-1] = busy;
            @(negedge clk);
        end
        chk("basic_instr_seq", {ins[1], ins[2], ins[3]}, {3'd0, 3'd5, 3'd6});
        chk("basic_ld_addr", d2, 8'h10);
        chk("basic_ack_pattern", ak, 12'h150);
        chk("basic_irq_pattern", iq, 12'h400);
        chk("basic_busy_pattern", bz, 12'h3FF);
        chk("basic_beats", beats, 8'd3);
        dev_req = 0;

        // done already asserted on entry to WAIT_REQ
        force_done = 1; dev_req = 1;
        go(8'h20, 8'd5, 3'd0);
        na = 0; ni = 0;
        for (int k = 1; k <= 8; k++) begin
            na += int'(dev_ack); ni += int'(irq);
            @(negedge clk);
        end
        chk("done_no_ack", na, 0);
        chk("done_irq_once", ni, 1);
        chk("done_beats", beats, 8'd0);
        force_done = 0; dev_req = 0;

        // abort one cycle after the second ack
        dev_req = 1;
        go(8'h30, 8'd5, 3'd0);
        repeat (6) @(negedge clk);
        chk("abort_second_ack", dev_ack, 1'b1);
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0; dev_req = 0;
        chk("abort_state", {busy, err, irq, am_aci, am_wci, am_instr}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7});
        chk("abort_beats", beats, 8'd2);
        ni = 0;
        repeat (3) begin @(negedge clk); ni += int'(irq); end
        chk("abort_no_irq", ni, 0);

        // reset in the middle of a beat
        dev_req = 1;
        go(8'h40, 8'd5, 3'd0);
        repeat (4) @(negedge clk);
        chk("midrst_in_xfer", dev_ack, 1'b1);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_vals", {am_instr, am_data, am_aci, am_wci, am_oeaddr, dev_ack, busy, irq, err, beats}, RST_V);
        rst_n = 1; dev_req = 0;
        @(negedge clk);
        go(8'h80, 8'd2, 3'd1);
        chk("restart_wr_cr", {am_instr, am_data}, {3'd0, 8'd1});
        @(negedge clk);
        chk("restart_ld_addr", {am_instr, am_data}, {3'd5, 8'h80});
        @(negedge clk);
        chk("restart_ld_wc", {am_instr, am_data}, {3'd6, 8'd2});
        dev_req = 1;
        repeat (7) @(negedge clk);
        chk("restart_done", {busy, beats}, {1'b0, 8'd2});
        dev_req = 0;

        // second start while busy must be ignored
        go(8'h20, 8'd2, 3'd4);
        cfg_addr = 8'h55; cfg_count = 8'd9; cfg_mode = 3'd1; start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_start_addr", {am_instr, am_data}, {3'd5, 8'h20});
        @(negedge clk);
        chk("busy_start_count", {am_instr, am_data}, {3'd6, 8'd2});
        dev_req = 1;
        repeat (7) @(negedge clk);
        chk("busy_start_end", {busy, err, beats}, {1'b0, 1'b0, 8'd2});
        chk("busy_start_addr_down", a_addr, 8'h1E);
        dev_req = 0;

`ifdef AM2940_SEQ_TIMEOUT_EN
        go(8'h50, 8'd3, 3'd0);
        repeat (10) @(negedge clk);
        chk("wdog_before", {busy, irq}, {1'b1, 1'b0});
        @(negedge clk);
        chk("wdog_fire", {busy, irq, err}, {1'b0, 1'b1, 1'b1});
        @(negedge clk);
`else
        go(8'h50, 8'd3, 3'd0);
        repeat (20) @(negedge clk);
        chk("nowdog_waiting", {busy, irq, err}, {1'b1, 1'b0, 1'b0});
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("nowdog_abort", {busy, err}, {1'b0, 1'b1});
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
